// File: rtl/alu_pipe_if.sv
// Handshake and data bundle between the operand source, the pipelined ALU and the result consumer.
// WIDTH/CNT_W must match the parameters of the attached alu_pipe.
interface alu_pipe_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       f;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             zero;
   logic             carry;
   logic             overflow;
   logic             negative;
   logic [CNT_W-1:0] op_count;

   modport master (
      output in_valid, f, a, b, out_ready,
      input  in_ready, out_valid, y, zero, carry, overflow, negative, op_count
   );

   modport slave (
      input  in_valid, f, a, b, out_ready,
      output in_ready, out_valid, y, zero, carry, overflow, negative, op_count
   );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 registers operands, S2 computes and registers result plus flags.
// Valid/ready on both sides with full backpressure and a wrapping completed-operation counter.
module alu_pipe #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input logic        clk,
   input logic        reset_n,
   alu_pipe_if.slave  bus
);
   logic             s1_valid_q, s1_valid_d;
   logic [2:0]       s1_f_q, s1_f_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;
   logic             overflow_q, overflow_d;
   logic             negative_q, negative_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;

   logic             s2_free_s;
   logic             in_ready_s;
   logic             accept_s;
   logic             xfer_s;
   logic             retire_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   diff_s;
   logic             ovf_add_s;
   logic             ovf_sub_s;
   logic [WIDTH-1:0] res_y_s;
   logic             res_c_s;
   logic             res_o_s;

   // Handshake qualifiers; in_ready looks only at pipeline state and out_ready.
   always_comb begin
      s2_free_s  = !out_valid_q || bus.out_ready;
      in_ready_s = !s1_valid_q || s2_free_s;
      accept_s   = bus.in_valid && in_ready_s;
      xfer_s     = s1_valid_q && s2_free_s;
      retire_s   = out_valid_q && bus.out_ready;
   end

   // Datapath: result and flags from the S1 operands.
   always_comb begin
      sum_s     = {1'b0, s1_a_q} + {1'b0, s1_b_q};
      diff_s    = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + {{WIDTH{1'b0}}, 1'b1};
      ovf_add_s = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (sum_s[WIDTH-1] != s1_a_q[WIDTH-1]);
      ovf_sub_s = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (diff_s[WIDTH-1] != s1_a_q[WIDTH-1]);
      res_y_s   = {WIDTH{1'b0}};
      res_c_s   = 1'b0;
      res_o_s   = 1'b0;
      case (s1_f_q)
         3'b000: res_y_s = s1_a_q & s1_b_q;
         3'b001: res_y_s = s1_a_q | s1_b_q;
         3'b010: begin
            res_y_s = sum_s[WIDTH-1:0];
            res_c_s = sum_s[WIDTH];
            res_o_s = ovf_add_s;
         end
         // Unsigned less-than is a borrow out of a - b.
         3'b011: res_y_s = {{(WIDTH-1){1'b0}}, ~diff_s[WIDTH]};
         3'b100: res_y_s = s1_a_q & ~s1_b_q;
         3'b101: res_y_s = s1_a_q | ~s1_b_q;
         3'b110: begin
            res_y_s = diff_s[WIDTH-1:0];
            res_c_s = diff_s[WIDTH];
            res_o_s = ovf_sub_s;
         end
         // Signed less-than stays correct across overflow by correcting the sign.
         3'b111: res_y_s = {{(WIDTH-1){1'b0}}, diff_s[WIDTH-1] ^ ovf_sub_s};
         default: res_y_s = {WIDTH{1'b0}};
      endcase
   end

   // Next-state for both stages and the counter.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_f_d      = s1_f_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      out_valid_d = out_valid_q;
      y_d         = y_q;
      zero_d      = zero_q;
      carry_d     = carry_q;
      overflow_d  = overflow_q;
      negative_d  = negative_q;
      op_count_d  = op_count_q;

      if (accept_s) begin
         s1_valid_d = 1'b1;
         s1_f_d     = bus.f;
         s1_a_d     = bus.a;
         s1_b_d     = bus.b;
      end else if (xfer_s) begin
         s1_valid_d = 1'b0;
      end else begin
         s1_valid_d = s1_valid_q;
      end

      if (xfer_s) begin
         out_valid_d = 1'b1;
         y_d         = res_y_s;
         zero_d      = (res_y_s == {WIDTH{1'b0}});
         carry_d     = res_c_s;
         overflow_d  = res_o_s;
         negative_d  = res_y_s[WIDTH-1];
      end else if (retire_s) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end

      if (retire_s) begin
         op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         op_count_d = op_count_q;
      end
   end

   // Pipeline and counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q  <= 1'b0;
         s1_f_q      <= 3'b000;
         s1_a_q      <= {WIDTH{1'b0}};
         s1_b_q      <= {WIDTH{1'b0}};
         out_valid_q <= 1'b0;
         y_q         <= {WIDTH{1'b0}};
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
         negative_q  <= 1'b0;
         op_count_q  <= {CNT_W{1'b0}};
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_f_q      <= s1_f_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         zero_q      <= zero_d;
         carry_q     <= carry_d;
         overflow_q  <= overflow_d;
         negative_q  <= negative_d;
         op_count_q  <= op_count_d;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;
   assign bus.zero      = zero_q;
   assign bus.carry     = carry_q;
   assign bus.overflow  = overflow_q;
   assign bus.negative  = negative_q;
   assign bus.op_count  = op_count_q;
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the single-cycle 32-bit ALU. It uses the same 3-bit function encoding.
- New versus the single-cycle ALU: generic data width, carry/overflow/negative flags alongside zero, unsigned compare, valid/ready handshakes on input and output with full backpressure, and a completed-operation counter.
- Sits between the operand source (register file / test sequencer) and the result consumer.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 2).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and function presented.
- in_ready  output  1  block can accept this cycle.
- f  input  3  function code.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer accepts the result.
- y  output  WIDTH  result.
- zero  output  1  y == 0.
- carry  output  1  carry-out (ADD/SUB only).
- overflow  output  1  signed overflow (ADD/SUB only).
- negative  output  1  y[WIDTH-1].
- op_count  output  CNT_W  number of output handshakes completed.

Behaviour:
- Function codes:
  - 000 = a & b
  - 001 = a | b
  - 010 = a + b
  - 011 = SLTU: y = {0…, a < b unsigned}
  - 100 = a & ~b
  - 101 = a | ~b
  - 110 = a − b
  - 111 = SLT: y = {0…, a < b signed}
- SLT must be correct even when a − b overflows: use sign(a−b) XOR overflow.
- ADD flags:
  - carry = bit WIDTH of a + b
  - overflow = (a[MSB] == b[MSB]) && (y[MSB] != a[MSB])
- SUB flags, computed as a + ~b + 1:
  - carry = carry-out (1 = no borrow)
  - overflow = (a[MSB] != b[MSB]) && (y[MSB] != a[MSB])
- All other codes: carry = 0, overflow = 0. zero and negative are always derived from y.
- Stage 1 (S1) registers f, a, b plus s1_valid. Stage 2 (S2) computes from S1 and registers y, the four flags and out_valid.
- Input handshake:
  - Accept when in_valid && in_ready.
  - in_ready = !s1_valid || s2_free, where s2_free = !out_valid || out_ready.
  - in_ready must not depend combinationally on in_valid.
- S1 → S2 transfer happens when s1_valid && s2_free.
- Output handshake:
  - Result retires when out_valid && out_ready.
  - While out_valid && !out_ready, y and all flags hold stable.
- Latency: 2 cycles from accept edge to out_valid high, with no stall.
- Throughput: 1 op/cycle with out_ready held high.
- Ordering is strictly FIFO. No op is dropped or duplicated under any stall pattern.
- Simultaneous events:
  - S1 may accept a new op in the same cycle it hands its current op to S2.
  - S2 may load a new result in the same cycle its old result retires.
- op_count:
  - Increments by 1 on each output handshake.
  - Wraps from 2^CNT_W−1 to 0.
- Reset (asynchronous assert, synchronous release):
  - s1_valid, out_valid, y, all flags and op_count = 0.
  - in_ready = 1 in the first cycle after release.
- Reset mid-operation discards all in-flight ops; none appear after release.

Test Plan:
- Reset, then accept f=010, a=0x7FFFFFFF, b=1 with out_ready=1 → two cycles later out_valid=1, y=0x80000000, overflow=1, negative=1, carry=0, zero=0; op_count=1 after the handshake.
- Issue f=110 a=5 b=5, then f=111 a=0x80000000 b=1, then f=011 a=0x80000000 b=1, back-to-back:
  - results in order: y=0 zero=1 carry=1; then y=1 (signed less); then y=0 (unsigned not less).
  - out_valid high three consecutive cycles.
- Hold out_ready=0 for 5 cycles while driving 4 ops → in_ready drops after 2 accepted; y/flags stable throughout; on release all 4 results emerge in order; op_count=4.
- Cover logic ops with a=0xF0F0F0F0, b=0xFF00FF00:
  - 000 → 0xF000F000
  - 001 → 0xFFF0FFF0
  - 100 → 0x00F000F0
  - 101 → 0xF0FFF0FF
  - carry=overflow=0 for all four.
- Assert reset_n low with 2 ops in flight → outputs 0 immediately (asynchronous); after release no stale result appears; op_count=0.
- WIDTH=8, CNT_W=2:
  - a=0xFF, b=0x01, f=010 → y=0x00, zero=1, carry=1, overflow=0.
  - 5 retired ops → op_count wraps to 1.
